wb_bypass_pipe: RTL and testbench

Producer side of the EX-stage operand-forwarding interface: registers the MEM-stage result into the WB stage and a one-deep post-writeback BUF stage, drives the register-file write port from WB, and publishes the three (write-enable, write-address, data) tiers, MEM, WB and BUF, consumed by the forwarding mux selector. It guarantees that every published write-enable is forwarding-safe: no writes to register 0, no load data from MEM, no flushed or bubble slots. It sits between the MEM pipeline register and the register file, alongside the hazard/stall logic.

---
 rtl/wb_bypass_pipe_pkg.sv | 19 +
 rtl/wb_bypass_pipe_if.sv | 46 ++++
 rtl/wb_bypass_pipe_wb_stage_reg.sv | 29 ++
 rtl/wb_bypass_pipe.sv | 81 ++++++++
 tb/tb_wb_bypass_pipe.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_bypass_pipe_pkg.sv
// rtl/wb_bypass_pipe_pkg.sv - shared pipeline widths, zero-register constant and WB slot type
package wb_bypass_pipe_pkg;

    localparam int PKG_DATA_W = 32;
    localparam int PKG_ADDR_W = 5;

    localparam logic [PKG_ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic                  valid;
        logic                  wen;
        logic [PKG_ADDR_W-1:0] waddr;
        logic                  is_load;
        logic [PKG_DATA_W-1:0] alu;
    } wb_slot_t;

    localparam wb_slot_t WB_BUBBLE = '0;

endpackage

// File: rtl/wb_bypass_pipe_if.sv
// rtl/wb_bypass_pipe_if.sv - MEM-side inputs and MEM/WB/BUF forwarding tiers
interface wb_bypass_pipe_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
);
    logic              mem_valid;
    logic              mem_rf_wen;
    logic [ADDR_W-1:0] mem_rf_waddr;
    logic              mem_is_load;
    logic [DATA_W-1:0] mem_alu_result;
    logic [DATA_W-1:0] dmem_rdata;
    logic              stall_i;
    logic              flush_i;

    logic              rf_wen_MEM;
    logic [ADDR_W-1:0] rf_waddr_MEM;
    logic [DATA_W-1:0] fwd_data_MEM;
    logic              rf_wen_WB;
    logic [ADDR_W-1:0] rf_waddr_WB;
    logic [DATA_W-1:0] fwd_data_WB;
    logic              rf_wen_BUF;
    logic [ADDR_W-1:0] rf_waddr_BUF;
    logic [DATA_W-1:0] fwd_data_BUF;
    logic              load_pending_MEM;
    logic [CNT_W-1:0]  retired_cnt;

    modport slave (
        input  mem_valid, mem_rf_wen, mem_rf_waddr, mem_is_load, mem_alu_result,
               dmem_rdata, stall_i, flush_i,
        output rf_wen_MEM, rf_waddr_MEM, fwd_data_MEM,
               rf_wen_WB, rf_waddr_WB, fwd_data_WB,
               rf_wen_BUF, rf_waddr_BUF, fwd_data_BUF,
               load_pending_MEM, retired_cnt
    );

    modport master (
        output mem_valid, mem_rf_wen, mem_rf_waddr, mem_is_load, mem_alu_result,
               dmem_rdata, stall_i, flush_i,
        input  rf_wen_MEM, rf_waddr_MEM, fwd_data_MEM,
               rf_wen_WB, rf_waddr_WB, fwd_data_WB,
               rf_wen_BUF, rf_waddr_BUF, fwd_data_BUF,
               load_pending_MEM, retired_cnt
    );

endinterface

// File: rtl/wb_bypass_pipe_wb_stage_reg.sv
// rtl/wb_bypass_pipe_wb_stage_reg.sv - stall/flush-aware pipeline slot register
module wb_stage_reg
    import wb_bypass_pipe_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     i_stall,
    input  logic     i_flush,
    input  wb_slot_t i_slot,
    output wb_slot_t o_slot
);

    wb_slot_t r_slot;
    logic     w_advance;

    // Flush beats stall: the killed slot must leave as a bubble even while the pipe is held.
    assign w_advance = ~i_stall | i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot <= WB_BUBBLE;
        end else if (w_advance) begin
            r_slot <= i_flush ? WB_BUBBLE : i_slot;
        end
    end

    assign o_slot = r_slot;

endmodule

// File: rtl/wb_bypass_pipe.sv
// rtl/wb_bypass_pipe.sv - WB/BUF registers, RF write port and forwarding-safe MEM/WB/BUF tiers
module wb_bypass_pipe
    import wb_bypass_pipe_pkg::*;
#(
    parameter int DATA_W = PKG_DATA_W,
    parameter int ADDR_W = PKG_ADDR_W,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    wb_bypass_pipe_if.slave  bus
);

    logic              w_mem_ok;
    logic              w_advance;
    wb_slot_t          w_mem_slot;
    wb_slot_t          w_wb_slot;
    logic [DATA_W-1:0] w_wb_data;

    logic              r_buf_wen;
    logic [ADDR_W-1:0] r_buf_waddr;
    logic [DATA_W-1:0] r_buf_data;
    logic [CNT_W-1:0]  r_retired_cnt;

    assign w_mem_ok  = bus.mem_valid & bus.mem_rf_wen
                     & (bus.mem_rf_waddr != ZERO_REG) & ~bus.flush_i;
    assign w_advance = ~bus.stall_i | bus.flush_i;

    // Load data is not available until WB, so loads never publish on the MEM tier.
    assign bus.rf_wen_MEM       = w_mem_ok & ~bus.mem_is_load;
    assign bus.rf_waddr_MEM     = bus.mem_rf_waddr;
    assign bus.fwd_data_MEM     = bus.mem_alu_result;
    assign bus.load_pending_MEM = w_mem_ok & bus.mem_is_load;

    assign w_mem_slot.valid   = bus.mem_valid;
    assign w_mem_slot.wen     = w_mem_ok;
    assign w_mem_slot.waddr   = bus.mem_rf_waddr;
    assign w_mem_slot.is_load = bus.mem_is_load;
    assign w_mem_slot.alu     = bus.mem_alu_result;

    wb_stage_reg u_wb_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_stall (bus.stall_i),
        .i_flush (bus.flush_i),
        .i_slot  (w_mem_slot),
        .o_slot  (w_wb_slot)
    );

    assign w_wb_data       = w_wb_slot.is_load ? bus.dmem_rdata : w_wb_slot.alu;
    assign bus.rf_wen_WB   = w_wb_slot.wen;
    assign bus.rf_waddr_WB = w_wb_slot.waddr;
    assign bus.fwd_data_WB = w_wb_data;

    // BUF bridges the RF write-then-read gap for one advancing cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_wen   <= 1'b0;
            r_buf_waddr <= '0;
            r_buf_data  <= '0;
        end else if (w_advance) begin
            r_buf_wen   <= w_wb_slot.wen;
            r_buf_waddr <= w_wb_slot.waddr;
            r_buf_data  <= w_wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired_cnt <= '0;
        end else if (w_advance && w_wb_slot.valid) begin
            r_retired_cnt <= r_retired_cnt + CNT_W'(1);
        end
    end

    assign bus.rf_wen_BUF   = r_buf_wen;
    assign bus.rf_waddr_BUF = r_buf_waddr;
    assign bus.fwd_data_BUF = r_buf_data;
    assign bus.retired_cnt  = r_retired_cnt;

endmodule

// File: tb/tb_wb_bypass_pipe.sv
// tb/tb_wb_bypass_pipe.sv - randomized and directed checks of wb_bypass_pipe against a reference model
module tb_wb_bypass_pipe;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic        t_valid, t_wen, t_load, t_stall, t_flush;
    logic [4:0]  t_addr;
    logic [31:0] t_alu, t_rdata;

    always #5 clk = ~clk;

    wb_bypass_pipe_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) bus_a ();
    wb_bypass_pipe_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  bus_b ();

    assign bus_a.mem_valid      = t_valid;
    assign bus_a.mem_rf_wen     = t_wen;
    assign bus_a.mem_rf_waddr   = t_addr;
    assign bus_a.mem_is_load    = t_load;
    assign bus_a.mem_alu_result = t_alu;
    assign bus_a.dmem_rdata     = t_rdata;
    assign bus_a.stall_i        = t_stall;
    assign bus_a.flush_i        = t_flush;

    assign bus_b.mem_valid      = t_valid;
    assign bus_b.mem_rf_wen     = t_wen;
    assign bus_b.mem_rf_waddr   = t_addr;
    assign bus_b.mem_is_load    = t_load;
    assign bus_b.mem_alu_result = t_alu;
    assign bus_b.dmem_rdata     = t_rdata;
    assign bus_b.stall_i        = t_stall;
    assign bus_b.flush_i        = t_flush;

    wb_bypass_pipe #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    wb_bypass_pipe #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: the instruction sitting in WB, the write published in BUF, retirements so far.
    logic        m_wb_valid, m_wb_wen, m_wb_load;
    logic [4:0]  m_wb_addr;
    logic [31:0] m_wb_alu;
    logic        m_buf_wen;
    logic [4:0]  m_buf_addr;
    logic [31:0] m_buf_data;
    logic [31:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic mem_ok();
        return t_valid && t_wen && (t_addr != 5'd0) && !t_flush;
    endfunction

    function automatic logic [31:0] wb_data();
        return m_wb_load ? t_rdata : m_wb_alu;
    endfunction

    task automatic model_reset();
        m_wb_valid = 1'b0; m_wb_wen = 1'b0; m_wb_load = 1'b0;
        m_wb_addr  = '0;   m_wb_alu = '0;
        m_buf_wen  = 1'b0; m_buf_addr = '0; m_buf_data = '0;
        m_cnt      = '0;
    endtask

    task automatic model_step();
        if (!rst_n) begin
            model_reset();
        end else if (!t_stall || t_flush) begin
            if (m_wb_valid) m_cnt = m_cnt + 1;
            m_buf_wen  = m_wb_wen;
            m_buf_addr = m_wb_addr;
            m_buf_data = wb_data();
            if (t_flush) begin
                m_wb_valid = 1'b0; m_wb_wen = 1'b0; m_wb_load = 1'b0;
                m_wb_addr  = '0;   m_wb_alu = '0;
            end else begin
                m_wb_valid = t_valid;
                m_wb_wen   = mem_ok();
                m_wb_addr  = t_addr;
                m_wb_load  = t_load;
                m_wb_alu   = t_alu;
            end
        end
    endtask

    task automatic compare_all();
        chk("rf_wen_MEM",       bus_a.rf_wen_MEM,       mem_ok() && !t_load);
        chk("rf_waddr_MEM",     bus_a.rf_waddr_MEM,     t_addr);
        chk("fwd_data_MEM",     bus_a.fwd_data_MEM,     t_alu);
        chk("load_pending_MEM", bus_a.load_pending_MEM, mem_ok() && t_load);
        chk("rf_wen_WB",        bus_a.rf_wen_WB,        m_wb_wen);
        chk("rf_waddr_WB",      bus_a.rf_waddr_WB,      m_wb_addr);
        chk("fwd_data_WB",      bus_a.fwd_data_WB,      wb_data());
        chk("rf_wen_BUF",       bus_a.rf_wen_BUF,       m_buf_wen);
        chk("rf_waddr_BUF",     bus_a.rf_waddr_BUF,     m_buf_addr);
        chk("fwd_data_BUF",     bus_a.fwd_data_BUF,     m_buf_data);
        chk("retired_cnt",      bus_a.retired_cnt,      m_cnt);
        chk("retired_cnt_w4",   bus_b.retired_cnt,      m_cnt & 32'hF);
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [4:0] a, input logic ld,
                         input logic [31:0] alu, input logic [31:0] rd,
                         input logic st, input logic fl);
        t_valid = v; t_wen = w; t_addr = a; t_load = ld;
        t_alu = alu; t_rdata = rd; t_stall = st; t_flush = fl;
        #1;
    endtask

    task automatic idle(input logic [31:0] rd);
        drive(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, rd, 1'b0, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        idle(32'h0);
        cycle();
        cycle();
        chk("reset rf_wen_WB",    bus_a.rf_wen_WB,    32'd0);
        chk("reset rf_wen_BUF",   bus_a.rf_wen_BUF,   32'd0);
        chk("reset fwd_data_BUF", bus_a.fwd_data_BUF, 32'd0);
        chk("reset retired_cnt",  bus_a.retired_cnt,  32'd0);
        rst_n = 1'b1;

        // ALU write through MEM, WB, BUF
        drive(1'b1, 1'b1, 5'd5, 1'b0, 32'h1234, $urandom, 1'b0, 1'b0);
        chk("alu MEM wen",  bus_a.rf_wen_MEM,   32'd1);
        chk("alu MEM addr", bus_a.rf_waddr_MEM, 32'd5);
        chk("alu MEM data", bus_a.fwd_data_MEM, 32'h1234);
        cycle();
        idle($urandom);
        chk("alu WB wen",  bus_a.rf_wen_WB,   32'd1);
        chk("alu WB addr", bus_a.rf_waddr_WB, 32'd5);
        chk("alu WB data", bus_a.fwd_data_WB, 32'h1234);
        cycle();
        chk("alu BUF wen",  bus_a.rf_wen_BUF,   32'd1);
        chk("alu BUF addr", bus_a.rf_waddr_BUF, 32'd5);
        chk("alu BUF data", bus_a.fwd_data_BUF, 32'h1234);
        chk("alu retired",  bus_a.retired_cnt,  32'd1);

        // Load: data arrives from dmem in WB
        drive(1'b1, 1'b1, 5'd7, 1'b1, 32'h100, $urandom, 1'b0, 1'b0);
        chk("load MEM wen",     bus_a.rf_wen_MEM,       32'd0);
        chk("load pending",     bus_a.load_pending_MEM, 32'd1);
        cycle();
        idle(32'hCAFE);
        chk("load WB wen",  bus_a.rf_wen_WB,   32'd1);
        chk("load WB addr", bus_a.rf_waddr_WB, 32'd7);
        chk("load WB data", bus_a.fwd_data_WB, 32'hCAFE);
        cycle();
        chk("load BUF data", bus_a.fwd_data_BUF, 32'hCAFE);

        // Register zero is never forwarded
        drive(1'b1, 1'b1, 5'd0, 1'b1, 32'h55, $urandom, 1'b0, 1'b0);
        chk("r0 load pending", bus_a.load_pending_MEM, 32'd0);
        drive(1'b1, 1'b1, 5'd0, 1'b0, 32'h55, $urandom, 1'b0, 1'b0);
        chk("r0 MEM wen", bus_a.rf_wen_MEM, 32'd0);
        cycle();
        idle($urandom);
        chk("r0 WB wen", bus_a.rf_wen_WB, 32'd0);
        cycle();
        chk("r0 BUF wen",  bus_a.rf_wen_BUF,  32'd0);
        chk("r0 retired",  bus_a.retired_cnt, 32'd3);

        // Stall for three cycles, then flush while still stalled
        drive(1'b1, 1'b1, 5'd9, 1'b0, 32'h99, $urandom, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 1'b1, 5'd10, 1'b0, 32'hAA, t_rdata, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall WB wen",  bus_a.rf_wen_WB,   32'd1);
            chk("stall WB addr", bus_a.rf_waddr_WB, 32'd9);
            chk("stall WB data", bus_a.fwd_data_WB, 32'h99);
            chk("stall BUF wen", bus_a.rf_wen_BUF,  32'd0);
            chk("stall retired", bus_a.retired_cnt, 32'd3);
        end
        drive(1'b1, 1'b1, 5'd10, 1'b0, 32'hAA, t_rdata, 1'b1, 1'b1);
        chk("flush MEM wen", bus_a.rf_wen_MEM, 32'd0);
        cycle();
        idle($urandom);
        chk("flush WB wen",   bus_a.rf_wen_WB,    32'd0);
        chk("flush BUF wen",  bus_a.rf_wen_BUF,   32'd1);
        chk("flush BUF addr", bus_a.rf_waddr_BUF, 32'd9);
        chk("flush BUF data", bus_a.fwd_data_BUF, 32'h99);
        chk("flush retired",  bus_a.retired_cnt,  32'd4);
        cycle();
        chk("flushed BUF wen",  bus_a.rf_wen_BUF,   32'd0);
        chk("flushed BUF addr", bus_a.rf_waddr_BUF, 32'd0);

        // Reset mid-stream with a live WB write
        drive(1'b1, 1'b1, 5'd3, 1'b0, 32'h33, $urandom, 1'b0, 1'b0);
        cycle();
        cycle();
        chk("pre-reset WB wen", bus_a.rf_wen_WB, 32'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async reset WB wen",  bus_a.rf_wen_WB,    32'd0);
        chk("async reset BUF wen", bus_a.rf_wen_BUF,   32'd0);
        chk("async reset BUF dat", bus_a.fwd_data_BUF, 32'd0);
        chk("async reset cnt",     bus_a.retired_cnt,  32'd0);
        idle($urandom);
        cycle();
        rst_n = 1'b1;

        // 17 retirements wrap the 4-bit counter to 1
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b1, 5'($urandom_range(1, 31)), 1'b0, $urandom, $urandom, 1'b0, 1'b0);
            cycle();
        end
        idle($urandom);
        cycle();
        chk("wrap cnt w4",  bus_b.retired_cnt, 32'd1);
        chk("wrap cnt w32", bus_a.retired_cnt, 32'd17);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] rd;
            rd = t_stall ? t_rdata : $urandom;
            drive($urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 7)),
                  $urandom_range(0, 2) == 0,
                  $urandom,
                  rd,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
